// File: rtl/up_down_sweep_ctrl.sv
// Sweep sequencer: runs a WIDTH-bit counter back and forth between latched
// lo/hi limits for a programmed number of sweeps, with busy/done/err handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; outputs hold, done/err pulses clear
// UP      | counting toward hi; reverses to DOWN on the hi cycle
// DOWN    | counting toward lo; next sweep or completion on the lo cycle
module up_down_sweep_ctrl #(
  parameter int WIDTH = 4,
  parameter int SW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [SW-1:0]    sweeps,
  output logic [WIDTH-1:0] count,
  output logic             mode,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [SW-1:0]    sweeps_left
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  localparam logic [WIDTH-1:0] ONE_C = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0]    ONE_S = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0]    ZERO_S = '0;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [SW-1:0]    sweeps_left_q, sweeps_left_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  logic start_ok;
  logic at_hi;
  logic at_lo;
  logic last_sweep;

  assign start_ok   = (lo < hi) && (sweeps != ZERO_S);
  assign at_hi      = (count_q == hi_q);
  assign at_lo      = (count_q == lo_q);
  assign last_sweep = (sweeps_left_q <= ONE_S);

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    mode_d        = mode_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    sweeps_left_d = sweeps_left_q;
    lo_d          = lo_q;
    hi_d          = hi_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (start_ok) begin
            lo_d          = lo;
            hi_d          = hi;
            count_d       = lo;
            mode_d        = 1'b1;
            busy_d        = 1'b1;
            sweeps_left_d = sweeps;
            state_d       = ST_UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_UP, ST_DOWN: begin
        if (abort) begin
          // count and mode deliberately keep their last values
          state_d       = ST_IDLE;
          busy_d        = 1'b0;
          sweeps_left_d = ZERO_S;
        end else if (!hold) begin
          if (state_q == ST_UP) begin
            if (!at_hi) begin
              count_d = count_q + ONE_C;
            end else begin
              count_d = count_q - ONE_C;
              mode_d  = 1'b0;
              state_d = ST_DOWN;
            end
          end else begin
            if (!at_lo) begin
              count_d = count_q - ONE_C;
            end else if (!last_sweep) begin
              count_d       = lo_q + ONE_C;
              mode_d        = 1'b1;
              sweeps_left_d = sweeps_left_q - ONE_S;
              state_d       = ST_UP;
            end else begin
              state_d       = ST_IDLE;
              busy_d        = 1'b0;
              done_d        = 1'b1;
              sweeps_left_d = ZERO_S;
            end
          end
        end
      end

      default: begin
        state_d       = ST_IDLE;
        busy_d        = 1'b0;
        sweeps_left_d = ZERO_S;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      mode_q        <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      sweeps_left_q <= '0;
      lo_q          <= '0;
      hi_q          <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      mode_q        <= mode_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      sweeps_left_q <= sweeps_left_d;
      lo_q          <= lo_d;
      hi_q          <= hi_d;
    end
  end

  assign count       = count_q;
  assign mode        = mode_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign sweeps_left = sweeps_left_q;

endmodule
